mp_alu_seq: RTL and testbench

//   Multi-precision add/subtract sequencer built around the 16-bit ALU (ALU_16bits).

---
 rtl/mp_alu_seq_pkg.sv | 22 ++
 rtl/mp_alu_seq_alu.sv | 62 ++++++
 rtl/mp_alu_seq.sv | 205 ++++++++++++++++++++
 tb/tb_mp_alu_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// mp_alu_seq_pkg
//   Shared definitions for the multi-precision add/subtract sequencer and its
//   16-bit ALU: FSM state encodings, ALU control bit positions and ALU width.
// -----------------------------------------------------------------------------
package mp_alu_seq_pkg;

  // Datapath width of the shared ALU.
  localparam int ALU_W = 16;

  // Bit positions inside the 2-bit ALU control field.
  localparam int ALU_SIGN = 0;  // signed overflow detection enabled
  localparam int ALU_COMP = 1;  // complement operand b (subtract)

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : mp_alu_seq_pkg

// File: rtl/mp_alu_seq_alu.sv
// -----------------------------------------------------------------------------
// ALU_16bits
//   Combinational 16-bit adder/subtractor shared by the wide-op sequencer.
//   s = a + (alu_ctrl[ALU_COMP] ? ~b : b) + c_pre
// Ports
//   a, b      in  16  operands
//   c_pre     in  1   carry in from the previous (less significant) word
//   alu_ctrl  in  2   {complement b, signed}
//   s         out 16  sum
//   c         out 1   carry out of bit 15
//   z         out 1   s == 0
//   n         out 1   s[15]
//   v         out 1   two's-complement overflow, only when the signed bit is set
// -----------------------------------------------------------------------------
module ALU_16bits
  import mp_alu_seq_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             c_pre,
  input  logic [1:0]       alu_ctrl,
  output logic [ALU_W-1:0] s,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v
);

  logic [ALU_W-1:0] b_eff_s;
  logic [ALU_W:0]   sum_s;

  // Add with optional operand complement and derive the flags.
  always_comb begin
    b_eff_s = b;
    sum_s   = {(ALU_W + 1){1'b0}};
    s       = {ALU_W{1'b0}};
    c       = 1'b0;
    z       = 1'b0;
    n       = 1'b0;
    v       = 1'b0;

    if (alu_ctrl[ALU_COMP]) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end

    sum_s = {1'b0, a} + {1'b0, b_eff_s} + {{ALU_W{1'b0}}, c_pre};
    s     = sum_s[ALU_W-1:0];
    c     = sum_s[ALU_W];
    z     = (sum_s[ALU_W-1:0] == {ALU_W{1'b0}});
    n     = sum_s[ALU_W-1];

    // Overflow: both addends share a sign that differs from the result sign.
    if (alu_ctrl[ALU_SIGN]) begin
      v = (a[ALU_W-1] == b_eff_s[ALU_W-1]) && (sum_s[ALU_W-1] != a[ALU_W-1]);
    end else begin
      v = 1'b0;
    end
  end

endmodule : ALU_16bits

// File: rtl/mp_alu_seq.sv
// -----------------------------------------------------------------------------
// mp_alu_seq
//   Multi-precision add/subtract sequencer. Accepts one WORDS x 16-bit
//   operation per request handshake, runs it through the shared 16-bit ALU one
//   word per cycle (least-significant word first, carry chained), and returns
//   the full result plus aggregate Z/C/N/V flags on a response handshake.
// Ports
//   clk, rst_n           clock, async active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_a, req_b         W-bit operands, W = 16*WORDS
//   req_sub              1: A + ~B + cin, 0: A + B + cin
//   req_signed           signed interpretation (ALU sign bit on MS word only)
//   req_cin              carry into word 0
//   rsp_valid/rsp_ready  response handshake
//   rsp_s                W-bit result
//   rsp_z/c/n/v          all-zero, MS-word carry, result sign, MS-word overflow
//   busy                 an operation is running or awaiting response pickup
// -----------------------------------------------------------------------------
module mp_alu_seq
  import mp_alu_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ALU_W*WORDS-1:0]   req_a,
  input  logic [ALU_W*WORDS-1:0]   req_b,
  input  logic                     req_sub,
  input  logic                     req_signed,
  input  logic                     req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ALU_W*WORDS-1:0]   rsp_s,
  output logic                     rsp_z,
  output logic                     rsp_c,
  output logic                     rsp_n,
  output logic                     rsp_v,
  output logic                     busy
);

  localparam int W     = ALU_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state_r;
  state_t           state_nx_s;
  logic [IDX_W-1:0] idx_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic             sub_r;
  logic             signed_r;
  logic             carry_r;
  logic             zacc_r;
  logic [W-1:0]     result_r;
  logic             rsp_z_r;
  logic             rsp_c_r;
  logic             rsp_n_r;
  logic             rsp_v_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic             busy_r;

  logic             last_s;
  logic [ALU_W-1:0] alu_a_s;
  logic [ALU_W-1:0] alu_b_s;
  logic [1:0]       alu_ctrl_s;
  logic [ALU_W-1:0] alu_s_s;
  logic             alu_c_s;
  logic             alu_z_s;
  logic             alu_n_s;
  logic             alu_v_s;

  // ALU operand selection: every input comes from registered state.
  always_comb begin
    last_s     = (idx_r == LAST_IDX);
    alu_a_s    = a_r[{idx_r, 4'b0000} +: ALU_W];
    alu_b_s    = b_r[{idx_r, 4'b0000} +: ALU_W];
    alu_ctrl_s = 2'b00;
    alu_ctrl_s[ALU_COMP] = sub_r;
    // Signed overflow only means something on the most-significant word.
    alu_ctrl_s[ALU_SIGN] = signed_r && last_s;
  end

  ALU_16bits u_alu (
    .a        (alu_a_s),
    .b        (alu_b_s),
    .c_pre    (carry_r),
    .alu_ctrl (alu_ctrl_s),
    .s        (alu_s_s),
    .c        (alu_c_s),
    .z        (alu_z_s),
    .n        (alu_n_s),
    .v        (alu_v_s)
  );

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register with handshake/status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      req_ready_r <= (state_nx_s == ST_IDLE);
      rsp_valid_r <= (state_nx_s == ST_DONE);
      busy_r      <= (state_nx_s == ST_RUN) || (state_nx_s == ST_DONE);
    end
  end

  // Operand latch on accept, per-word execution in RUN, flag capture on last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r    <= {IDX_W{1'b0}};
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      sub_r    <= 1'b0;
      signed_r <= 1'b0;
      carry_r  <= 1'b0;
      zacc_r   <= 1'b0;
      result_r <= {W{1'b0}};
      rsp_z_r  <= 1'b0;
      rsp_c_r  <= 1'b0;
      rsp_n_r  <= 1'b0;
      rsp_v_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            a_r      <= req_a;
            b_r      <= req_b;
            sub_r    <= req_sub;
            signed_r <= req_signed;
            carry_r  <= req_cin;
            idx_r    <= {IDX_W{1'b0}};
            zacc_r   <= 1'b1;
          end
        end
        ST_RUN: begin
          result_r[{idx_r, 4'b0000} +: ALU_W] <= alu_s_s;
          carry_r <= alu_c_s;
          zacc_r  <= zacc_r & alu_z_s;
          if (last_s) begin
            // idx stays at the last word; it is reloaded on the next accept.
            rsp_z_r <= zacc_r & alu_z_s;
            rsp_c_r <= alu_c_s;
            rsp_n_r <= alu_n_s;
            rsp_v_r <= alu_v_s;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        ST_DONE: begin
          // Response held stable until the consumer takes it.
        end
        default: begin
          idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign busy      = busy_r;
  assign rsp_s     = result_r;
  assign rsp_z     = rsp_z_r;
  assign rsp_c     = rsp_c_r;
  assign rsp_n     = rsp_n_r;
  assign rsp_v     = rsp_v_r;

endmodule : mp_alu_seq

// File: tb/tb_mp_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_mp_alu_seq
//   Directed self-checking bench for mp_alu_seq with WORDS=4 (64-bit ops).
// -----------------------------------------------------------------------------
module tb_mp_alu_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_sub;
  logic         req_signed;
  logic         req_cin;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_s;
  logic         rsp_z;
  logic         rsp_c;
  logic         rsp_n;
  logic         rsp_v;
  logic         busy;

  int errors;
  int checks;

  mp_alu_seq #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .req_signed (req_signed),
    .req_cin    (req_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_s      (rsp_s),
    .rsp_z      (rsp_z),
    .rsp_c      (rsp_c),
    .rsp_n      (rsp_n),
    .rsp_v      (rsp_v),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request in IDLE, let it be accepted, then wait (bounded) for
  // rsp_valid. cyc is the cycle index at which rsp_valid was seen, counting
  // the accept cycle as 0. rsp_ready is left low so the response is held.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic sgn, input logic cin,
                          output int cyc, output logic got);
    @(negedge clk);
    req_a      = a;
    req_b      = b;
    req_sub    = sub;
    req_signed = sgn;
    req_cin    = cin;
    req_valid  = 1'b1;
    rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    got = rsp_valid;
  endtask

  task automatic finish_op();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_sub = 1'b0; req_signed = 1'b0; req_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b busy=%b valid=%b required 1 0 0", req_ready, busy, rsp_valid);
    end
    checks++;
    if (rsp_s !== 64'h0 || {rsp_z, rsp_c, rsp_n, rsp_v} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_data: s=%h zcnv=%b%b%b%b required 0 0000", rsp_s, rsp_z, rsp_c, rsp_n, rsp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_carry();
    int cyc; logic got;
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, cyc, got);
    checks++;
    if (!got || cyc !== 5) begin
      errors++;
      $display("FAIL add_latency: valid=%b cycle=%0d required valid at cycle 5", got, cyc);
    end
    checks++;
    if (rsp_s !== 64'h0000_0000_0001_0000 || {rsp_z, rsp_c, rsp_v} !== 3'b000) begin
      errors++;
      $display("FAIL add_carry: s=%h zcv=%b%b%b required 0000000000010000 000", rsp_s, rsp_z, rsp_c, rsp_v);
    end
    finish_op();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_release: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_sub_borrow();
    int cyc; logic got;
    start_op(64'h0000_0001_0000_0000, 64'h1, 1'b1, 1'b0, 1'b1, cyc, got);
    checks++;
    if (!got || rsp_s !== 64'h0000_0000_FFFF_FFFF || {rsp_z, rsp_c, rsp_n} !== 3'b010) begin
      errors++;
      $display("FAIL sub_borrow: valid=%b s=%h zcn=%b%b%b required 00000000FFFFFFFF 010", got, rsp_s, rsp_z, rsp_c, rsp_n);
    end
    finish_op();
  endtask

  task automatic test_signed_wrap();
    int cyc; logic got;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 1'b0, cyc, got);
    checks++;
    if (!got || rsp_s !== 64'h0 || {rsp_z, rsp_c, rsp_n, rsp_v} !== 4'b1100) begin
      errors++;
      $display("FAIL signed_wrap: valid=%b s=%h zcnv=%b%b%b%b required 0 1100", got, rsp_s, rsp_z, rsp_c, rsp_n, rsp_v);
    end
    finish_op();
  endtask

  task automatic test_signed_overflow();
    int cyc; logic got;
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 1'b0, cyc, got);
    checks++;
    if (!got || rsp_s !== 64'h8000_0000_0000_0000 || {rsp_z, rsp_c, rsp_n, rsp_v} !== 4'b0011) begin
      errors++;
      $display("FAIL signed_ovf: valid=%b s=%h zcnv=%b%b%b%b required 8000000000000000 0011", got, rsp_s, rsp_z, rsp_c, rsp_n, rsp_v);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int cyc; logic got;
    start_op(64'h3, 64'h4, 1'b0, 1'b0, 1'b0, cyc, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_first_valid: valid=%b required 1", got);
    end
    // Second request held high while the first response is back-pressured.
    req_a = 64'h10; req_b = 64'h20; req_sub = 1'b0; req_signed = 1'b0; req_cin = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_s !== 64'h7 || req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_hold%0d: valid=%b s=%h ready=%b busy=%b required 1 7 0 1", i, rsp_valid, rsp_s, req_ready, busy);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handshake: valid=%b ready=%b busy=%b required 0 1 0", rsp_valid, req_ready, busy);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b ready=%b required 1 0", busy, req_ready);
    end
    // Operands were latched on accept; disturbing the inputs must not matter.
    req_a = 64'hDEAD_BEEF_0000_1111; req_b = 64'h1234;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || cyc !== 5 || rsp_s !== 64'h30) begin
      errors++;
      $display("FAIL b2b_second: valid=%b cycle=%0d s=%h required 1 5 30", rsp_valid, cyc, rsp_s);
    end
    finish_op();
  endtask

  task automatic test_reset_mid_run();
    int cyc; logic got;
    @(negedge clk);
    req_a = 64'hFFFF_0000_FFFF_0000; req_b = 64'h0001_0001_0001_0001;
    req_sub = 1'b0; req_signed = 1'b0; req_cin = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    // Now processing word idx==2: pulse reset between clock edges.
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_s !== 64'h0) begin
      errors++;
      $display("FAIL midrun_async: ready=%b busy=%b valid=%b s=%h required 1 0 0 0", req_ready, busy, rsp_valid, rsp_s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) got = 1'b1;
    end
    checks++;
    if (got !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_rsp: saw valid=%b required 0", got);
    end
    start_op(64'h1, 64'h1, 1'b0, 1'b0, 1'b0, cyc, got);
    checks++;
    if (!got || rsp_s !== 64'h2 || {rsp_z, rsp_c, rsp_n, rsp_v} !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_next: valid=%b s=%h zcnv=%b%b%b%b required 2 0000", got, rsp_s, rsp_z, rsp_c, rsp_n, rsp_v);
    end
    finish_op();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_signed_wrap();
    test_signed_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mp_alu_seq
